// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, counter widths and command bytes
// Used by both the host transmitter and the keyboard receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        BITS,
        ACK,
        WAIT_IDLE,
        DONE
    } ps2_state_e;

    // Wide enough for a 20 ms timeout at 50 MHz.
    localparam int CNT_W     = 20;
    localparam int BIT_IDX_W = 4;

    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] ACK_BYTE    = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-FF synchronizer, run-length glitch filter and fall pulse
// One instance per PS/2 line; the filtered level idles high.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic fall
);

    localparam int             FW       = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0]  CNT_LAST = FW'(FILTER_LEN - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [FW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          fall_q, fall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        sync1_d = line_in;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        // The counter tracks how long the sample has disagreed with the accepted level.
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + FW'(1);
        end
        fall_d = level_q & ~level_d;
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Drives the open-drain lines only through active-high pull-low enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sel,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    logic clk_level, clk_fall;
    logic data_level, data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (ps2_clk_in),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (ps2_data_in),
        .level   (data_level),
        .fall    (data_fall_unused)
    );

    ps2_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0] idx_q, idx_d;
    logic [7:0]           byte_q, byte_d;
    logic                 parity_q, parity_d;
    logic                 clk_oe_q, clk_oe_d;
    logic                 data_oe_q, data_oe_d;
    logic                 err_q, err_d;
    logic                 tx_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            byte_q    <= '0;
            parity_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            byte_q    <= byte_d;
            parity_q  <= parity_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            err_q     <= err_d;
        end
    end

    // Index 8 selects the parity bit; index 9 is handled as the stop bit.
    assign tx_bit = idx_q[3] ? parity_q : byte_q[idx_q[2:0]];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        byte_d    = byte_q;
        parity_d  = parity_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (sel && tx_start) begin
                    byte_d   = tx_data;
                    parity_d = odd_parity(tx_data);
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = START;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    clk_oe_d = 1'b0;
                    state_d  = BITS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BITS, ACK, WAIT_IDLE: begin
                // Timeout wins over a clock fall landing in the same cycle.
                if (cnt_q == TO_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (state_q == BITS) begin
                        if (clk_fall) begin
                            idx_d = idx_q + BIT_IDX_W'(1);
                            if (idx_q == BIT_IDX_W'(9)) begin
                                data_oe_d = 1'b0;
                                state_d   = ACK;
                            end else begin
                                data_oe_d = ~tx_bit;
                            end
                        end
                    end else if (state_q == ACK) begin
                        if (clk_fall) begin
                            err_d   = data_level;
                            state_d = WAIT_IDLE;
                        end
                    end else if (clk_level && data_level) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
// Shortened cycle parameters keep every scenario, including the timeout, fast.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 300;
    localparam int STC = 20;
    localparam int TOC = 4000;
    localparam int FLT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, err;
    logic       ps2_clk_line, ps2_data_line;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_CYCLES   (STC),
        .TIMEOUT_CYCLES (TOC),
        .FILTER_LEN     (FLT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel         (sel),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame as the device sees it: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = (($countones(d) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] d);
        @(posedge clk); #1;
        sel = 1'b1; tx_start = 1'b1; tx_data = d;
        @(posedge clk); #1;
        sel = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_err_clear", 32'(err), 32'd0);
    endtask

    task automatic dev_receive(input int half, input bit ack, input int npulses,
                               output logic [10:0] smp, output bit ok);
        int w;
        smp = '1;
        ok  = 1'b0;
        w   = 0;
        while (!(ps2_data_oe && !ps2_clk_oe) && w < 20000) begin
            @(posedge clk); #1;
            w++;
        end
        if (w < 20000) begin
            ok = 1'b1;
            repeat (half) @(posedge clk);
            #1;
            smp[0] = ps2_data_line;
            for (int p = 0; p < npulses; p++) begin
                dev_clk_low = 1'b1;
                repeat (half) @(posedge clk);
                #1;
                dev_clk_low = 1'b0;
                if (p == 10) dev_data_low = 1'b0;
                if (p < 10) smp[p+1] = ps2_data_line;
                if (p == 9) dev_data_low = ack;
                repeat (half) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic run_monitor(output int t_cr, output int t_dr, output int t_cf, output int t_dn,
                               output logic e, output int n_done, output bit oe_ok);
        int post;
        t_cr = -1; t_dr = -1; t_cf = -1; t_dn = -1;
        e = 1'b0; n_done = 0; oe_ok = 1'b0; post = -1;
        for (int k = 0; k < 20000 && post != 0; k++) begin
            @(negedge clk);
            if (ps2_clk_oe && t_cr < 0) t_cr = cyc;
            if (ps2_data_oe && t_dr < 0) t_dr = cyc;
            if (!ps2_clk_oe && t_cr >= 0 && t_cf < 0) t_cf = cyc;
            if (done) begin
                n_done++;
                if (t_dn < 0) begin
                    t_dn  = cyc;
                    e     = err;
                    oe_ok = !ps2_clk_oe && !ps2_data_oe;
                    post  = 6;
                end
            end
            if (post > 0) post--;
        end
    endtask

    task automatic run_transfer(input logic [7:0] d, input bit ack, input bit exp_err,
                                input int half, input string tag);
        logic [10:0] smp;
        bit          dok, ook;
        int          tcr, tdr, tcf, tdn, nd;
        logic        e;
        send(d);
        fork
            dev_receive(half, ack, 11, smp, dok);
            run_monitor(tcr, tdr, tcf, tdn, e, nd, ook);
        join
        chk({tag, "_dev_request"}, 32'(dok), 32'd1);
        chk({tag, "_frame"}, 32'(smp), 32'(frame_of(d)));
        chk({tag, "_done_seen"}, 32'(tdn >= 0), 32'd1);
        chk({tag, "_err"}, 32'(e), 32'(exp_err));
        chk({tag, "_done_pulses"}, 32'(nd), 32'd1);
        chk({tag, "_lines_released"}, 32'(ook), 32'd1);
        chk({tag, "_inhibit_len"}, 32'(tdr - tcr), 32'(INH));
        chk({tag, "_start_len"}, 32'(tcf - tdr), 32'(STC));
        repeat (20) @(posedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        logic [10:0] smp;
        bit          dok, ook;
        int          tcr, tdr, tcf, tdn, nd;
        logic        e;

        vecs[0] = '{CMD_SET_LED, 1'b1, 1'b0};
        vecs[1] = '{CMD_ENABLE,  1'b1, 1'b0};
        vecs[2] = '{8'h00,       1'b1, 1'b0};
        vecs[3] = '{ACK_BYTE,    1'b0, 1'b1};
        vecs[4] = '{CMD_RESET,   1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("reset_data_oe", 32'(ps2_data_oe), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        for (int i = 0; i < 5; i++)
            run_transfer(vecs[i].data, vecs[i].ack, vecs[i].exp_err, 40, $sformatf("vec%0d", i));

        for (int r = 0; r < 6; r++) begin
            logic [7:0] d;
            bit         ack;
            int         half;
            d    = 8'($urandom_range(0, 255));
            ack  = ($urandom_range(0, 3) != 0);
            half = $urandom_range(25, 60);
            run_transfer(d, ack, !ack, half, $sformatf("rnd%0d", r));
        end

        // Device never clocks: the transfer must end on the timeout.
        send(CMD_ENABLE);
        run_monitor(tcr, tdr, tcf, tdn, e, nd, ook);
        chk("timeout_done_seen", 32'(tdn >= 0), 32'd1);
        chk("timeout_latency", 32'(tdn - tcf), 32'(TOC));
        chk("timeout_err", 32'(e), 32'd1);
        chk("timeout_lines_released", 32'(ook), 32'd1);
        chk("timeout_done_pulses", 32'(nd), 32'd1);
        repeat (20) @(posedge clk);

        // Reset in the middle of the data bits (index 4, bit 3 = 0 on the line).
        send(8'h00);
        dev_receive(40, 1'b1, 4, smp, dok);
        chk("midrst_dev_request", 32'(dok), 32'd1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("midrst_pre_data_oe", 32'(ps2_data_oe), 32'd1);
        chk("midrst_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        run_transfer(CMD_RESET, 1'b1, 1'b0, 40, "after_rst");

        // tx_start without sel, then a second start while busy.
        @(posedge clk); #1;
        sel = 1'b0; tx_start = 1'b1; tx_data = 8'h55;
        @(posedge clk); #1;
        tx_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sel0_ignored", 32'(busy), 32'd0);
        send(CMD_ENABLE);
        fork
            dev_receive(40, 1'b1, 11, smp, dok);
            run_monitor(tcr, tdr, tcf, tdn, e, nd, ook);
            begin
                repeat (100) @(posedge clk);
                #1;
                sel = 1'b1; tx_start = 1'b1; tx_data = 8'h12;
                @(posedge clk); #1;
                sel = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
            end
        join
        chk("busy_start_frame", 32'(smp), 32'(frame_of(CMD_ENABLE)));
        chk("busy_start_done_pulses", 32'(nd), 32'd1);
        chk("busy_start_err", 32'(e), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("busy_start_not_queued", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
